// File: rtl/prog_sync_fifo.sv
// -----------------------------------------------------------------------------
// prog_sync_fifo
//
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, a synchronous flush, and a choice of read
// behaviour:
//   FWFT = 0 : registered read. read_data loads on the edge of an accepted
//              read and read_valid pulses for the following cycle.
//   FWFT = 1 : first-word-fall-through. The head word is shown on read_data
//              whenever the FIFO is not empty; ren pops it. read_valid is 0.
//
// DEPTH may be any value 2..2**PTR_W. Pointers wrap explicitly at DEPTH-1, so
// non-power-of-two depths are supported.
//
// Ports
//   clk          in   sole clock, rising edge
//   rstb         in   asynchronous active-high reset
//   wren         in   write request
//   write_data   in   [DATA_W-1:0] write word
//   ren          in   read request
//   flush        in   synchronous empty command (overrides wren/ren)
//   clr_err      in   clears overflow/underflow
//   af_thresh    in   [PTR_W:0] almost_full when count >= af_thresh
//   ae_thresh    in   [PTR_W:0] almost_empty when count <= ae_thresh
//   read_data    out  [DATA_W-1:0] read word
//   read_valid   out  read_data qualifier (FWFT=0 only)
//   fifo_full    out  count == DEPTH
//   fifo_empty   out  count == 0
//   almost_full  out  threshold flag
//   almost_empty out  threshold flag
//   data_avail   out  [PTR_W:0] occupancy
//   room_avail   out  [PTR_W:0] free entries
//   overflow     out  sticky: write attempted while full
//   underflow    out  sticky: read attempted while empty
// -----------------------------------------------------------------------------
module prog_sync_fifo #(
  parameter int DATA_W = 32,
  parameter int PTR_W  = 4,
  parameter int DEPTH  = 16,
  parameter int FWFT   = 0
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              wren,
  input  logic [DATA_W-1:0] write_data,
  input  logic              ren,
  input  logic              flush,
  input  logic              clr_err,
  input  logic [PTR_W:0]    af_thresh,
  input  logic [PTR_W:0]    ae_thresh,
  output logic [DATA_W-1:0] read_data,
  output logic              read_valid,
  output logic              fifo_full,
  output logic              fifo_empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [PTR_W:0]    data_avail,
  output logic [PTR_W:0]    room_avail,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [PTR_W-1:0] LAST_IDX  = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic             IS_FWFT   = (FWFT != 0);

  // Storage is intentionally left out of reset.
  logic [DATA_W-1:0] r_mem [0:DEPTH-1];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_count;
  logic [DATA_W-1:0] r_read_data;
  logic              r_read_valid;
  logic              r_overflow;
  logic              r_underflow;

  logic              w_full;
  logic              w_empty;
  logic              w_wr_acc;
  logic              w_rd_acc;
  logic [PTR_W:0]    w_count_nxt;
  logic [DATA_W-1:0] w_head;

  // Pointer increment with explicit wrap at DEPTH-1 so that non-power-of-two
  // depths never index past the end of the array.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    if (p == LAST_IDX) begin
      return '0;
    end
    return p + PTR_ONE;
  endfunction

  // Status decode straight from the registered count, no added latency.
  assign w_full  = (r_count == DEPTH_CNT);
  assign w_empty = (r_count == '0);

  // Flush takes priority: a flushed cycle accepts neither side, which also
  // keeps the memory untouched during a flush.
  assign w_wr_acc = wren & ~w_full  & ~flush;
  assign w_rd_acc = ren  & ~w_empty & ~flush;

  assign w_head = r_mem[r_rd_ptr];

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_wr_acc, w_rd_acc})
      2'b10:   w_count_nxt = r_count + CNT_ONE;
      2'b01:   w_count_nxt = r_count - CNT_ONE;
      default: w_count_nxt = r_count;
    endcase
  end

  // ---- write side: memory array (no reset) ----
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= write_data;
    end
  end

  // ---- pointers and occupancy ----
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= ptr_next(r_wr_ptr);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      r_count <= w_count_nxt;
    end
  end

  // ---- registered read port ----
  // Only used in FWFT=0; in FWFT=1 it stays at its reset value and acts as the
  // idle value of read_data while the FIFO is empty.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_read_data  <= '0;
      r_read_valid <= 1'b0;
    end else begin
      r_read_valid <= w_rd_acc & ~IS_FWFT;
      if (w_rd_acc && !IS_FWFT) begin
        r_read_data <= w_head;
      end
    end
  end

  // ---- sticky error flags ----
  // Errors are judged on the request against the current full/empty state,
  // independent of flush. A new error in a clr_err cycle keeps the flag set.
  always_ff @(posedge clk or posedge rstb) begin
    if (rstb) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (wren & w_full)  | (r_overflow  & ~clr_err);
      r_underflow <= (ren  & w_empty) | (r_underflow & ~clr_err);
    end
  end

  // ---- outputs ----
  // In FWFT mode the head word is driven combinationally whenever there is
  // data. During reset the count is already zero, so the empty path selects
  // the reset-cleared register and read_data reads 0 without a clock edge.
  assign read_data    = (IS_FWFT && !w_empty) ? w_head : r_read_data;
  assign read_valid   = r_read_valid;
  assign fifo_full    = w_full;
  assign fifo_empty   = w_empty;
  assign almost_full  = (r_count >= af_thresh);
  assign almost_empty = (r_count <= ae_thresh);
  assign data_avail   = r_count;
  assign room_avail   = DEPTH_CNT - r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_prog_sync_fifo.sv
module tb_prog_sync_fifo;

  logic clk;
  logic rstb;

  // DUT a: DEPTH=16, FWFT=0
  logic        a_wren, a_ren, a_flush, a_clr;
  logic [31:0] a_wd, a_rd;
  logic [4:0]  a_af, a_ae, a_cnt, a_room;
  logic        a_rv, a_full, a_empty, a_afl, a_ael, a_ovf, a_udf;

  // DUT b: DEPTH=12, FWFT=0
  logic        b_wren, b_ren, b_flush, b_clr;
  logic [31:0] b_wd, b_rd;
  logic [4:0]  b_af, b_ae, b_cnt, b_room;
  logic        b_rv, b_full, b_empty, b_afl, b_ael, b_ovf, b_udf;

  // DUT c: DEPTH=16, FWFT=1
  logic        c_wren, c_ren, c_flush, c_clr;
  logic [31:0] c_wd, c_rd;
  logic [4:0]  c_af, c_ae, c_cnt, c_room;
  logic        c_rv, c_full, c_empty, c_afl, c_ael, c_ovf, c_udf;

  int n_checks = 0;
  int n_fail   = 0;

  prog_sync_fifo #(.DATA_W(32), .PTR_W(4), .DEPTH(16), .FWFT(0)) u_a (
    .clk(clk), .rstb(rstb), .wren(a_wren), .write_data(a_wd), .ren(a_ren),
    .flush(a_flush), .clr_err(a_clr), .af_thresh(a_af), .ae_thresh(a_ae),
    .read_data(a_rd), .read_valid(a_rv), .fifo_full(a_full), .fifo_empty(a_empty),
    .almost_full(a_afl), .almost_empty(a_ael), .data_avail(a_cnt), .room_avail(a_room),
    .overflow(a_ovf), .underflow(a_udf));

  prog_sync_fifo #(.DATA_W(32), .PTR_W(4), .DEPTH(12), .FWFT(0)) u_b (
    .clk(clk), .rstb(rstb), .wren(b_wren), .write_data(b_wd), .ren(b_ren),
    .flush(b_flush), .clr_err(b_clr), .af_thresh(b_af), .ae_thresh(b_ae),
    .read_data(b_rd), .read_valid(b_rv), .fifo_full(b_full), .fifo_empty(b_empty),
    .almost_full(b_afl), .almost_empty(b_ael), .data_avail(b_cnt), .room_avail(b_room),
    .overflow(b_ovf), .underflow(b_udf));

  prog_sync_fifo #(.DATA_W(32), .PTR_W(4), .DEPTH(16), .FWFT(1)) u_c (
    .clk(clk), .rstb(rstb), .wren(c_wren), .write_data(c_wd), .ren(c_ren),
    .flush(c_flush), .clr_err(c_clr), .af_thresh(c_af), .ae_thresh(c_ae),
    .read_data(c_rd), .read_valid(c_rv), .fifo_full(c_full), .fifo_empty(c_empty),
    .almost_full(c_afl), .almost_empty(c_ael), .data_avail(c_cnt), .room_avail(c_room),
    .overflow(c_ovf), .underflow(c_udf));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] q[$];
  logic [31:0] exp_w;
  bit          rd_ok, wr_ok;

  initial begin
    rstb = 1'b1;
    a_wren = 0; a_ren = 0; a_flush = 0; a_clr = 0; a_wd = '0; a_af = 5'd12; a_ae = 5'd3;
    b_wren = 0; b_ren = 0; b_flush = 0; b_clr = 0; b_wd = '0; b_af = 5'd12; b_ae = 5'd0;
    c_wren = 0; c_ren = 0; c_flush = 0; c_clr = 0; c_wd = '0; c_af = 5'd16; c_ae = 5'd0;

    // reset state
    #3;
    chk("rst_empty", 32'(a_empty), 32'd1);
    chk("rst_full",  32'(a_full),  32'd0);
    chk("rst_ae",    32'(a_ael),   32'd1);
    chk("rst_af",    32'(a_afl),   32'd0);
    chk("rst_cnt",   32'(a_cnt),   32'd0);
    chk("rst_room",  32'(a_room),  32'd16);
    chk("rst_rd",    a_rd,         32'd0);
    chk("rst_rv",    32'(a_rv),    32'd0);
    chk("rst_ovf",   32'(a_ovf),   32'd0);
    chk("rst_udf",   32'(a_udf),   32'd0);
    @(posedge clk);
    #1;
    rstb = 1'b0;

    // fill 0x0..0xF, watching thresholds
    for (int i = 0; i < 16; i++) begin
      a_wren = 1; a_wd = 32'(i);
      step();
      chk("fill_cnt", 32'(a_cnt), 32'(i + 1));
      chk("fill_af",  32'(a_afl), 32'((i + 1) >= 12));
      chk("fill_ae",  32'(a_ael), 32'((i + 1) <= 3));
    end
    a_wren = 0;
    chk("full_flag", 32'(a_full),  32'd1);
    chk("full_room", 32'(a_room),  32'd0);
    chk("full_emp",  32'(a_empty), 32'd0);

    // drain in order, each read followed by an idle cycle
    for (int i = 0; i < 16; i++) begin
      a_ren = 1;
      step();
      chk("rd_valid", 32'(a_rv), 32'd1);
      chk("rd_data",  a_rd,      32'(i));
      a_ren = 0;
      step();
      chk("rd_vpulse", 32'(a_rv), 32'd0);
      chk("rd_hold",   a_rd,      32'(i));
    end
    chk("drain_emp",  32'(a_empty), 32'd1);
    chk("drain_cnt",  32'(a_cnt),   32'd0);
    chk("drain_room", 32'(a_room),  32'd16);

    // underflow, error wins over clr_err, then clear
    a_ren = 1;
    step();
    chk("udf_set", 32'(a_udf), 32'd1);
    chk("udf_rv",  32'(a_rv),  32'd0);
    chk("udf_cnt", 32'(a_cnt), 32'd0);
    a_clr = 1;
    step();
    chk("udf_win", 32'(a_udf), 32'd1);
    a_ren = 0;
    step();
    chk("udf_clr", 32'(a_udf), 32'd0);
    a_clr = 0;

    // refill then wren+ren while full
    for (int i = 0; i < 16; i++) begin
      a_wren = 1; a_wd = 32'h20 + 32'(i);
      step();
    end
    chk("refill_full", 32'(a_full), 32'd1);
    a_wren = 1; a_ren = 1; a_wd = 32'hEE;
    step();
    a_wren = 0; a_ren = 0;
    chk("both_cnt", 32'(a_cnt),  32'd15);
    chk("both_ovf", 32'(a_ovf),  32'd1);
    chk("both_rv",  32'(a_rv),   32'd1);
    chk("both_rd",  a_rd,        32'h20);
    chk("both_ful", 32'(a_full), 32'd0);
    a_clr = 1;
    step();
    a_clr = 0;
    chk("ovf_clr",  32'(a_ovf), 32'd0);
    chk("clr_cnt",  32'(a_cnt), 32'd15);

    // flush with wren, overflow must not be touched
    a_ovf_set: begin
      a_flush = 1; a_wren = 1; a_wd = 32'hBB;
      step();
      a_flush = 0; a_wren = 0;
    end
    chk("fl_cnt",  32'(a_cnt),   32'd0);
    chk("fl_emp",  32'(a_empty), 32'd1);
    chk("fl_rv",   32'(a_rv),    32'd0);
    chk("fl_room", 32'(a_room),  32'd16);

    // fill to 12, flush with wren
    for (int i = 0; i < 12; i++) begin
      a_wren = 1; a_wd = 32'h40 + 32'(i);
      step();
      chk("f12_af", 32'(a_afl), 32'((i + 1) >= 12));
      chk("f12_ae", 32'(a_ael), 32'((i + 1) <= 3));
    end
    a_flush = 1; a_wren = 1; a_wd = 32'hCC;
    step();
    a_flush = 0; a_wren = 0;
    chk("fl12_cnt", 32'(a_cnt), 32'd0);
    chk("fl12_af",  32'(a_afl), 32'd0);
    chk("fl12_ae",  32'(a_ael), 32'd1);

    // pointers restart at 0 after flush
    a_wren = 1; a_wd = 32'h55;
    step();
    a_wren = 0; a_ren = 1;
    step();
    chk("pf_rd",  a_rd,        32'h55);
    chk("pf_rv",  32'(a_rv),   32'd1);
    chk("pf_emp", 32'(a_empty), 32'd1);
    step();
    a_ren = 0;
    chk("pf_udf", 32'(a_udf), 32'd1);

    // async reset with count 7
    for (int i = 0; i < 7; i++) begin
      a_wren = 1; a_wd = 32'h60 + 32'(i);
      step();
    end
    a_wren = 0;
    chk("pre_cnt", 32'(a_cnt), 32'd7);
    #1;
    rstb = 1'b1;
    #1;
    chk("ar_cnt",  32'(a_cnt),   32'd0);
    chk("ar_emp",  32'(a_empty), 32'd1);
    chk("ar_full", 32'(a_full),  32'd0);
    chk("ar_ae",   32'(a_ael),   32'd1);
    chk("ar_af",   32'(a_afl),   32'd0);
    chk("ar_room", 32'(a_room),  32'd16);
    chk("ar_rd",   a_rd,         32'd0);
    chk("ar_rv",   32'(a_rv),    32'd0);
    chk("ar_udf",  32'(a_udf),   32'd0);
    #1;
    rstb = 1'b0;
    a_wren = 1; a_wd = 32'h77;
    step();
    a_wren = 0;
    chk("post_cnt", 32'(a_cnt), 32'd1);
    a_ren = 1;
    step();
    a_ren = 0;
    chk("post_rd", a_rd, 32'h77);

    // DEPTH=12 interleaved traffic with wrap
    q.delete();
    for (int k = 0; k < 30; k++) begin
      b_wren = 1; b_wd = 32'h100 + 32'(k);
      b_ren = (k >= 8);
      rd_ok = b_ren && (q.size() > 0);
      wr_ok = (q.size() < 12);
      exp_w = 32'h100 + 32'(k);
      step();
      if (rd_ok) begin
        chk("b_rd", b_rd, q.pop_front());
      end
      if (wr_ok) q.push_back(exp_w);
      chk("b_rv",  32'(b_rv),  32'(rd_ok));
      chk("b_cnt", 32'(b_cnt), 32'(q.size()));
    end
    b_wren = 0;
    for (int k = 0; k < 20 && q.size() > 0; k++) begin
      b_ren = 1;
      step();
      chk("b_drd", b_rd,      q.pop_front());
      chk("b_drv", 32'(b_rv), 32'd1);
    end
    b_ren = 0;
    step();
    chk("b_emp", 32'(b_empty), 32'd1);
    chk("b_ovf", 32'(b_ovf),   32'd0);
    chk("b_udf", 32'(b_udf),   32'd0);
    chk("b_rv0", 32'(b_rv),    32'd0);

    // FWFT mode
    chk("c_rd0",  c_rd,         32'd0);
    chk("c_emp0", 32'(c_empty), 32'd1);
    c_wren = 1; c_wd = 32'hA5;
    step();
    c_wren = 0;
    chk("c_rdA5", c_rd,         32'hA5);
    chk("c_emp1", 32'(c_empty), 32'd0);
    chk("c_rv",   32'(c_rv),    32'd0);
    step();
    chk("c_hold", c_rd, 32'hA5);
    c_wren = 1; c_wd = 32'h5A;
    step();
    c_wren = 0;
    chk("c_head", c_rd,       32'hA5);
    chk("c_cnt2", 32'(c_cnt), 32'd2);
    c_ren = 1;
    step();
    chk("c_pop1", c_rd,       32'h5A);
    chk("c_cnt1", 32'(c_cnt), 32'd1);
    chk("c_rvp",  32'(c_rv),  32'd0);
    step();
    c_ren = 0;
    chk("c_emp2", 32'(c_empty), 32'd1);
    chk("c_cnt0", 32'(c_cnt),   32'd0);
    chk("c_udf",  32'(c_udf),   32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
